// File: rtl/aes128_req_ctrl.sv
// Command front-end for aes128_core: queues requests, issues one operation at a
// time, and returns each result (or a timeout error) with its tag in command order.
module aes128_req_ctrl #(
  parameter int unsigned FIFO_DEPTH = 2,
  parameter int unsigned TAG_W      = 4,
  parameter int unsigned TIMEOUT    = 64
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             cmd_valid_i,
  output logic             cmd_ready_o,
  input  logic             cmd_dec_i,
  input  logic [127:0]     cmd_key_i,
  input  logic [127:0]     cmd_text_i,
  input  logic [TAG_W-1:0] cmd_tag_i,
  output logic             rsp_valid_o,
  input  logic             rsp_ready_i,
  output logic [127:0]     rsp_text_o,
  output logic [TAG_W-1:0] rsp_tag_o,
  output logic             rsp_err_o,
  output logic             core_start_enc_o,
  output logic             core_start_dec_o,
  output logic [127:0]     core_key_o,
  output logic [127:0]     core_text_o,
  input  logic [127:0]     core_text_i,
  input  logic             core_ready_i,
  input  logic             core_done_i,
  output logic             busy_o
);

  localparam int unsigned TXT_W = 128;
  localparam int unsigned PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int unsigned CNT_W = PTR_W + 1;
  localparam int unsigned TMR_W = $clog2(TIMEOUT);

  typedef struct packed {
    logic             dec;
    logic [TXT_W-1:0] key;
    logic [TXT_W-1:0] text;
    logic [TAG_W-1:0] tag;
  } cmd_t;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    START = 2'd1,
    WAIT  = 2'd2,
    RESP  = 2'd3
  } state_t;

  cmd_t             mem [FIFO_DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, rd_ptr_q;
  logic [CNT_W-1:0] count_q, count_d;
  logic             push, pop, full, empty;
  cmd_t             head;

  state_t           state_q, state_d;
  logic [TMR_W-1:0] timer_q, timer_d;

  logic [TXT_W-1:0] op_key_q, op_key_d;
  logic [TXT_W-1:0] op_text_q, op_text_d;
  logic [TAG_W-1:0] op_tag_q, op_tag_d;
  logic             start_enc_q, start_enc_d;
  logic             start_dec_q, start_dec_d;

  logic             rsp_valid_q, rsp_valid_d;
  logic [TXT_W-1:0] rsp_text_q, rsp_text_d;
  logic [TAG_W-1:0] rsp_tag_q, rsp_tag_d;
  logic             rsp_err_q, rsp_err_d;
  logic             busy_q, busy_d;

  assign full        = (count_q == CNT_W'(FIFO_DEPTH));
  assign empty       = (count_q == '0);
  assign cmd_ready_o = rst_n & ~full;
  assign push        = cmd_valid_i & cmd_ready_o;
  assign head        = mem[rd_ptr_q];

  // Queue storage needs no reset: occupancy is tracked by the pointers/count.
  always_ff @(posedge clk) begin
    if (push) begin
      mem[wr_ptr_q] <= {cmd_dec_i, cmd_key_i, cmd_text_i, cmd_tag_i};
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (push) wr_ptr_q <= wr_ptr_q + PTR_W'(1);
      if (pop)  rd_ptr_q <= rd_ptr_q + PTR_W'(1);
      count_q <= count_d;
    end
  end

  // Next-state, op capture and registered-output logic.
  always_comb begin
    state_d     = state_q;
    pop         = 1'b0;
    timer_d     = timer_q;
    op_key_d    = op_key_q;
    op_text_d   = op_text_q;
    op_tag_d    = op_tag_q;
    start_enc_d = 1'b0;
    start_dec_d = 1'b0;
    rsp_valid_d = rsp_valid_q;
    rsp_text_d  = rsp_text_q;
    rsp_tag_d   = rsp_tag_q;
    rsp_err_d   = rsp_err_q;

    case (state_q)
      IDLE: begin
        if (!empty && core_ready_i) begin
          pop         = 1'b1;
          op_key_d    = head.key;
          op_text_d   = head.text;
          op_tag_d    = head.tag;
          start_enc_d = ~head.dec;
          start_dec_d = head.dec;
          state_d     = START;
        end
      end
      START: begin
        timer_d = '0;
        state_d = WAIT;
      end
      WAIT: begin
        // A done on the final timer cycle still counts as success.
        if (core_done_i) begin
          rsp_text_d  = core_text_i;
          rsp_err_d   = 1'b0;
          rsp_tag_d   = op_tag_q;
          rsp_valid_d = 1'b1;
          state_d     = RESP;
        end else if (timer_q == TMR_W'(TIMEOUT - 1)) begin
          rsp_text_d  = '0;
          rsp_err_d   = 1'b1;
          rsp_tag_d   = op_tag_q;
          rsp_valid_d = 1'b1;
          state_d     = RESP;
        end else begin
          timer_d = timer_q + TMR_W'(1);
        end
      end
      RESP: begin
        if (rsp_ready_i) begin
          rsp_valid_d = 1'b0;
          state_d     = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase

    count_d = count_q + CNT_W'(push) - CNT_W'(pop);
    busy_d  = (state_d != IDLE) || (count_d != '0);
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      timer_q     <= '0;
      op_key_q    <= '0;
      op_text_q   <= '0;
      op_tag_q    <= '0;
      start_enc_q <= 1'b0;
      start_dec_q <= 1'b0;
      rsp_valid_q <= 1'b0;
      rsp_text_q  <= '0;
      rsp_tag_q   <= '0;
      rsp_err_q   <= 1'b0;
      busy_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      timer_q     <= timer_d;
      op_key_q    <= op_key_d;
      op_text_q   <= op_text_d;
      op_tag_q    <= op_tag_d;
      start_enc_q <= start_enc_d;
      start_dec_q <= start_dec_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_text_q  <= rsp_text_d;
      rsp_tag_q   <= rsp_tag_d;
      rsp_err_q   <= rsp_err_d;
      busy_q      <= busy_d;
    end
  end

  assign core_start_enc_o = start_enc_q;
  assign core_start_dec_o = start_dec_q;
  assign core_key_o       = op_key_q;
  assign core_text_o      = op_text_q;
  assign rsp_valid_o      = rsp_valid_q;
  assign rsp_text_o       = rsp_text_q;
  assign rsp_tag_o        = rsp_tag_q;
  assign rsp_err_o        = rsp_err_q;
  assign busy_o           = busy_q;

endmodule
